// File: rtl/calc1_pkg.sv
// calc1_pkg: shared calc1 command/response codes and scheduler state encoding
package calc1_pkg;
  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;
  localparam logic [1:0] RSP_NONE    = 2'd0;
  localparam logic [1:0] RSP_OK      = 2'd1;
  localparam logic [1:0] RSP_ERR     = 2'd2;
  localparam logic [1:0] RSP_TIMEOUT = 2'd3;
  typedef enum logic [2:0] {S_IDLE, S_SEND1, S_SEND2, S_WAIT, S_RESP} sched_state_t;
endpackage

// File: rtl/calc1_rr_arbiter.sv
// calc1_rr_arbiter: combinational round-robin grant, searching upward from ptr with wrap
module calc1_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant
);
  logic [PW-1:0] j;
  logic hit;
  always_comb begin
    grant = '0;
    hit = 1'b0;
    j = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = PW'((int'(ptr) + k) % N_REQ);
      if (!hit && req[j]) begin
        grant[j] = 1'b1;
        hit = 1'b1;
      end
    end
  end
endmodule

// File: rtl/calc1_req_scheduler.sv
// calc1_req_scheduler: round-robin sharing of one calc1 port, with response timeout
module calc1_req_scheduler
  import calc1_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int CMD_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    c_clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*CMD_W-1:0]  req_cmd,
  input  logic [N_REQ*DATA_W-1:0] req_op1,
  input  logic [N_REQ*DATA_W-1:0] req_op2,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [1:0]              rsp_resp,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [CMD_W-1:0]        alu_cmd,
  output logic [DATA_W-1:0]       alu_data,
  input  logic [1:0]              alu_resp,
  input  logic [DATA_W-1:0]       alu_data_in,
  output logic                    busy
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};
  sched_state_t state;
  logic [PW-1:0] ptr, id, id_n, ptr_n;
  logic [N_REQ-1:0] grant;
  logic [DATA_W-1:0] op2_q;
  logic [CW-1:0] cnt;
  logic [CMD_W-1:0] cmd_n;
  logic [DATA_W-1:0] op1_n, op2_n;
  calc1_rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .req  (req_valid),
    .ptr  (ptr),
    .grant(grant)
  );
  always_comb begin
    id_n = '0;
    for (int k = 0; k < N_REQ; k++) if (grant[k]) id_n = PW'(k);
  end
  assign ptr_n = PW'((int'(id_n) + 1) % N_REQ);
  assign cmd_n = req_cmd[int'(id_n)*CMD_W +: CMD_W];
  assign op1_n = req_op1[int'(id_n)*DATA_W +: DATA_W];
  assign op2_n = req_op2[int'(id_n)*DATA_W +: DATA_W];
  assign req_ready = (state == S_IDLE) ? grant : '0;
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      ptr <= '0;
      id <= '0;
      op2_q <= '0;
      cnt <= '0;
      alu_cmd <= '0;
      alu_data <= '0;
      rsp_valid <= '0;
      rsp_resp <= '0;
      rsp_data <= '0;
      busy <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (|req_ready) begin
          id <= id_n;
          op2_q <= op2_n;
          ptr <= ptr_n;
          busy <= 1'b1;
          // a NOP is answered locally and never reaches the ALU
          if (cmd_n == '0) begin
            state <= S_RESP;
            rsp_valid <= ONE << id_n;
            rsp_resp <= RSP_ERR;
            rsp_data <= '0;
          end else begin
            state <= S_SEND1;
            alu_cmd <= cmd_n;
            alu_data <= op1_n;
          end
        end
        S_SEND1: begin
          alu_cmd <= '0;
          alu_data <= op2_q;
          state <= S_SEND2;
        end
        S_SEND2: begin
          alu_data <= '0;
          cnt <= '0;
          state <= S_WAIT;
        end
        S_WAIT: if (alu_resp != RSP_NONE) begin
          rsp_valid <= ONE << id;
          rsp_resp <= alu_resp;
          rsp_data <= alu_data_in;
          state <= S_RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          rsp_valid <= ONE << id;
          rsp_resp <= RSP_TIMEOUT;
          rsp_data <= '0;
          state <= S_RESP;
        end else begin
          cnt <= cnt + CW'(1);
        end
        S_RESP: begin
          rsp_valid <= '0;
          busy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_calc1_req_scheduler.sv
// tb_calc1_req_scheduler: directed checks of arbitration, operand sequencing, timeout, reject and reset
module tb_calc1_req_scheduler;
  logic c_clk, reset;
  logic [3:0] req_valid;
  logic [15:0] req_cmd;
  logic [127:0] req_op1, req_op2;
  logic [3:0] req_ready, rsp_valid;
  logic [1:0] rsp_resp, alu_resp;
  logic [31:0] rsp_data, alu_data, alu_data_in;
  logic [3:0] alu_cmd;
  logic busy;
  int n_cmp = 0;
  int n_err = 0;
  calc1_req_scheduler #(.N_REQ(4), .DATA_W(32), .CMD_W(4), .TIMEOUT(16)) dut (
    .c_clk(c_clk), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_op1(req_op1), .req_op2(req_op2), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_resp(rsp_resp), .rsp_data(rsp_data), .alu_cmd(alu_cmd), .alu_data(alu_data),
    .alu_resp(alu_resp), .alu_data_in(alu_data_in), .busy(busy)
  );
  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;
  task automatic tick;
    @(posedge c_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_req(input int id, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_cmd[id*4 +: 4] = c;
    req_op1[id*32 +: 32] = a;
    req_op2[id*32 +: 32] = b;
  endtask
  // plays the calc1 side: dr==0 means the ALU never answers
  task automatic serve(input int id, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] dr, input logic [31:0] dd, input logic [1:0] er, input logic [31:0] ed);
    int got;
    #1;
    chk("grant", 64'(req_ready), 64'(1 << id));
    tick;
    chk("send1_cmd", 64'(alu_cmd), 64'(c));
    chk("send1_data", 64'(alu_data), 64'(a));
    chk("busy_high", 64'(busy), 64'd1);
    tick;
    chk("send2_cmd", 64'(alu_cmd), 64'd0);
    chk("send2_data", 64'(alu_data), 64'(b));
    tick;
    chk("wait_data", 64'(alu_data), 64'd0);
    chk("wait_no_rsp", 64'(rsp_valid), 64'd0);
    got = 0;
    if (dr != 2'd0) begin
      alu_resp = dr;
      alu_data_in = dd;
    end
    for (int i = 1; i <= 40 && got == 0; i++) begin
      tick;
      if (rsp_valid != 4'd0) got = i;
    end
    alu_resp = 2'd0;
    alu_data_in = 32'd0;
    chk("wait_cycles", 64'(got), (dr != 2'd0) ? 64'd1 : 64'd16);
    chk("rsp_valid", 64'(rsp_valid), 64'(1 << id));
    chk("rsp_resp", 64'(rsp_resp), 64'(er));
    chk("rsp_data", 64'(rsp_data), 64'(ed));
    tick;
    chk("rsp_pulse_end", 64'(rsp_valid), 64'd0);
    chk("rsp_resp_hold", 64'(rsp_resp), 64'(er));
    chk("rsp_data_hold", 64'(rsp_data), 64'(ed));
    chk("busy_low", 64'(busy), 64'd0);
  endtask
  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_cmd = '0;
    req_op1 = '0;
    req_op2 = '0;
    alu_resp = '0;
    alu_data_in = '0;
    #2 reset = 1'b0;
    tick;
    chk("rst_alu_cmd", 64'(alu_cmd), 64'd0);
    chk("rst_alu_data", 64'(alu_data), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_resp", 64'(rsp_resp), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    tick;
    reset = 1'b1;
    tick;
    set_req(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF);
    req_valid = 4'b0001;
    serve(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000, 2'd1, 32'h2000_0000);
    req_valid = 4'b0000;
    set_req(1, 4'd1, 32'hFFFF_FFFF, 32'h1);
    req_valid = 4'b0010;
    serve(1, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'h0, 2'd2, 32'h0);
    set_req(2, 4'd2, 32'h1, 32'hF);
    req_valid = 4'b0100;
    serve(2, 4'd2, 32'h1, 32'hF, 2'd2, 32'h0, 2'd2, 32'h0);
    set_req(3, 4'd6, 32'h80, 32'h3);
    req_valid = 4'b1000;
    serve(3, 4'd6, 32'h80, 32'h3, 2'd1, 32'h10, 2'd1, 32'h10);
    set_req(0, 4'd1, 32'h5, 32'h6);
    set_req(2, 4'd2, 32'h9, 32'h4);
    set_req(3, 4'd5, 32'h3, 32'h2);
    req_valid = 4'b1101;
    serve(0, 4'd1, 32'h5, 32'h6, 2'd1, 32'hB, 2'd1, 32'hB);
    serve(2, 4'd2, 32'h9, 32'h4, 2'd1, 32'h5, 2'd1, 32'h5);
    serve(3, 4'd5, 32'h3, 32'h2, 2'd1, 32'hC, 2'd1, 32'hC);
    #1;
    chk("rr_wrap_to_0", 64'(req_ready), 64'b0001);
    req_valid = 4'b0000;
    set_req(1, 4'd1, 32'h2, 32'h3);
    req_valid = 4'b0010;
    serve(1, 4'd1, 32'h2, 32'h3, 2'd0, 32'h0, 2'd3, 32'h0);
    req_valid = 4'b0000;
    alu_resp = 2'd1;
    alu_data_in = 32'h55;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("late_rsp_ignored", 64'(rsp_valid), 64'd0);
      chk("late_rsp_idle", 64'(busy), 64'd0);
    end
    alu_resp = 2'd0;
    alu_data_in = 32'd0;
    set_req(3, 4'd0, $urandom, $urandom);
    req_valid = 4'b1000;
    #1;
    chk("nop_grant", 64'(req_ready), 64'b1000);
    tick;
    req_valid = 4'b0000;
    chk("nop_rsp_valid", 64'(rsp_valid), 64'b1000);
    chk("nop_rsp_resp", 64'(rsp_resp), 64'd2);
    chk("nop_rsp_data", 64'(rsp_data), 64'd0);
    chk("nop_alu_cmd", 64'(alu_cmd), 64'd0);
    chk("nop_alu_data", 64'(alu_data), 64'd0);
    tick;
    chk("nop_pulse_end", 64'(rsp_valid), 64'd0);
    chk("nop_alu_cmd2", 64'(alu_cmd), 64'd0);
    chk("nop_busy_low", 64'(busy), 64'd0);
    set_req(0, 4'd1, 32'h7, 32'h8);
    req_valid = 4'b0001;
    #1;
    tick;
    req_valid = 4'b0000;
    tick;
    tick;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_alu_cmd", 64'(alu_cmd), 64'd0);
    chk("mid_rst_alu_data", 64'(alu_data), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_rsp_resp", 64'(rsp_resp), 64'd0);
    chk("mid_rst_rsp_data", 64'(rsp_data), 64'd0);
    tick;
    chk("mid_rst_no_pulse", 64'(rsp_valid), 64'd0);
    reset = 1'b1;
    tick;
    chk("post_rst_no_pulse", 64'(rsp_valid), 64'd0);
    set_req(2, 4'd5, 32'h1, 32'h4);
    req_valid = 4'b0100;
    serve(2, 4'd5, 32'h1, 32'h4, 2'd1, 32'h10, 2'd1, 32'h0000_0010);
    req_valid = 4'b0000;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
